port_prioritizer: RTL and testbench

Issue-side scheduler for the triple-ported memory. Accepts up to three requests per cycle, maps them onto the three physical memory ports under a rotating priority (physical port 1 = highest priority), and registers the result with a 2-bit origin tag per port. It also delays those tags by the memory read latency to produce the `orig_id` inputs of `port_deprioritizer`, which routes read data back to the originating requester.

---
 rtl/port_prioritizer.sv | 162 ++++++++++++++++
 tb/tb_port_prioritizer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_prioritizer.sv
// port_prioritizer: rotating-priority scheduler mapping three requesters onto three memory ports.
// Latency: issue 1 cycle; rsp_port*_orig_id trails the issue by MEM_LATENCY cycles.
// Backpressure: stall drops req_ready and freezes issue regs and rotation. PORT_PRIO_COMPACT_EN packs ports.
module port_prioritizer #(
    parameter int WIDTH       = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req2_valid,
    input  logic [WIDTH-1:0] req2_data,
    input  logic             req3_valid,
    input  logic [WIDTH-1:0] req3_data,
    input  logic             stall,
    output logic             req_ready,
    output logic             mem_port1_valid,
    output logic [WIDTH-1:0] mem_port1_data,
    output logic [1:0]       mem_port1_orig_id,
    output logic             mem_port2_valid,
    output logic [WIDTH-1:0] mem_port2_data,
    output logic [1:0]       mem_port2_orig_id,
    output logic             mem_port3_valid,
    output logic [WIDTH-1:0] mem_port3_data,
    output logic [1:0]       mem_port3_orig_id,
    output logic [1:0]       rsp_port1_orig_id,
    output logic [1:0]       rsp_port2_orig_id,
    output logic [1:0]       rsp_port3_orig_id
);

    typedef enum logic [1:0] {ROT0, ROT1, ROT2} rot_e;

    rot_e                       r_state;
    rot_e                       w_state_nxt;
    logic [2:0]                 w_req_vld;
    logic [2:0][WIDTH-1:0]      w_req_dat;
    logic                       w_accept;
    logic [2:0][1:0]            w_map;
    logic [2:0]                 w_slot_vld;
    logic [2:0][WIDTH-1:0]      w_slot_dat;
    logic [2:0][1:0]            w_slot_tag;
    logic [2:0]                 w_nxt_vld;
    logic [2:0][WIDTH-1:0]      w_nxt_dat;
    logic [2:0][1:0]            w_nxt_tag;
    logic [2:0]                 r_vld;
    logic [2:0][WIDTH-1:0]      r_dat;
    logic [2:0][1:0]            r_tag;
    logic                       r_issue_new;
    logic [MEM_LATENCY-1:0][2:0][1:0] r_rsp_pipe;

    assign w_req_vld = {req3_valid, req2_valid, req1_valid};
    assign w_req_dat = {req3_data, req2_data, req1_data};
    assign req_ready = ~stall;
    assign w_accept  = ~stall & (|w_req_vld);

    // w_map[s] is the requester index (0..2) owning priority slot s in the current rotation
    always_comb begin
        w_state_nxt = r_state;
        w_map       = {2'd2, 2'd1, 2'd0};
        case (r_state)
            ROT0: begin
                w_map = {2'd2, 2'd1, 2'd0};
                if (w_accept) w_state_nxt = ROT1;
            end
            ROT1: begin
                w_map = {2'd0, 2'd2, 2'd1};
                if (w_accept) w_state_nxt = ROT2;
            end
            ROT2: begin
                w_map = {2'd1, 2'd0, 2'd2};
                if (w_accept) w_state_nxt = ROT0;
            end
            default: w_state_nxt = ROT0;
        endcase
    end

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            w_slot_vld[s] = w_req_vld[w_map[s]];
            w_slot_dat[s] = w_req_dat[w_map[s]];
            w_slot_tag[s] = w_map[s] + 2'd1;
        end
    end

`ifdef PORT_PRIO_COMPACT_EN
    logic [1:0] w_fill;

    always_comb begin
        w_nxt_vld = '0;
        w_nxt_dat = '0;
        w_nxt_tag = '0;
        w_fill    = 2'd0;
        for (int s = 0; s < 3; s++) begin
            if (w_slot_vld[s]) begin
                w_nxt_vld[w_fill] = 1'b1;
                w_nxt_dat[w_fill] = w_slot_dat[s];
                w_nxt_tag[w_fill] = w_slot_tag[s];
                w_fill            = w_fill + 2'd1;
            end
        end
    end
`else
    always_comb begin
        w_nxt_vld = '0;
        w_nxt_dat = '0;
        w_nxt_tag = '0;
        for (int s = 0; s < 3; s++) begin
            if (w_slot_vld[s]) begin
                w_nxt_vld[s] = 1'b1;
                w_nxt_dat[s] = w_slot_dat[s];
                w_nxt_tag[s] = w_slot_tag[s];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ROT0;
            r_vld       <= '0;
            r_dat       <= '0;
            r_tag       <= '0;
            r_issue_new <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_issue_new <= ~stall;
            if (!stall) begin
                r_vld <= w_nxt_vld;
                r_dat <= w_nxt_dat;
                r_tag <= w_nxt_tag;
            end
        end
    end

    // Only a freshly loaded issue enters the pipe, so a held (stalled) issue is reported once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_pipe <= '0;
        end else begin
            r_rsp_pipe[0] <= r_issue_new ? r_tag : '0;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_rsp_pipe[i] <= r_rsp_pipe[i-1];
            end
        end
    end

    assign mem_port1_valid   = r_vld[0];
    assign mem_port1_data    = r_dat[0];
    assign mem_port1_orig_id = r_tag[0];
    assign mem_port2_valid   = r_vld[1];
    assign mem_port2_data    = r_dat[1];
    assign mem_port2_orig_id = r_tag[1];
    assign mem_port3_valid   = r_vld[2];
    assign mem_port3_data    = r_dat[2];
    assign mem_port3_orig_id = r_tag[2];

    assign rsp_port1_orig_id = r_rsp_pipe[MEM_LATENCY-1][0];
    assign rsp_port2_orig_id = r_rsp_pipe[MEM_LATENCY-1][1];
    assign rsp_port3_orig_id = r_rsp_pipe[MEM_LATENCY-1][2];

endmodule

// File: tb/tb_port_prioritizer.sv
// Testbench for port_prioritizer: directed scenarios plus randomized traffic against a reference model.
module tb_port_prioritizer;
    localparam int W   = 8;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] v = '0;
    logic [2:0][W-1:0] dd = '0;
    logic stall = 1'b0;

    logic req_ready;
    logic mem_port1_valid, mem_port2_valid, mem_port3_valid;
    logic [W-1:0] mem_port1_data, mem_port2_data, mem_port3_data;
    logic [1:0] mem_port1_orig_id, mem_port2_orig_id, mem_port3_orig_id;
    logic [1:0] rsp_port1_orig_id, rsp_port2_orig_id, rsp_port3_orig_id;

    logic [2:0]        a_vld;
    logic [2:0][W-1:0] a_dat;
    logic [2:0][1:0]   a_tag;
    logic [2:0][1:0]   a_rsp;

    assign a_vld = {mem_port3_valid, mem_port2_valid, mem_port1_valid};
    assign a_dat = {mem_port3_data, mem_port2_data, mem_port1_data};
    assign a_tag = {mem_port3_orig_id, mem_port2_orig_id, mem_port1_orig_id};
    assign a_rsp = {rsp_port3_orig_id, rsp_port2_orig_id, rsp_port1_orig_id};

    port_prioritizer #(.WIDTH(W), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req1_valid(v[0]), .req1_data(dd[0]),
        .req2_valid(v[1]), .req2_data(dd[1]),
        .req3_valid(v[2]), .req3_data(dd[2]),
        .stall(stall), .req_ready(req_ready),
        .mem_port1_valid(mem_port1_valid), .mem_port1_data(mem_port1_data), .mem_port1_orig_id(mem_port1_orig_id),
        .mem_port2_valid(mem_port2_valid), .mem_port2_data(mem_port2_data), .mem_port2_orig_id(mem_port2_orig_id),
        .mem_port3_valid(mem_port3_valid), .mem_port3_data(mem_port3_data), .mem_port3_orig_id(mem_port3_orig_id),
        .rsp_port1_orig_id(rsp_port1_orig_id), .rsp_port2_orig_id(rsp_port2_orig_id),
        .rsp_port3_orig_id(rsp_port3_orig_id)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: rotation counter, expected issue registers, and response schedule by cycle number
    int          m_rot;
    logic        m_vld [3];
    logic [W-1:0] m_dat [3];
    logic [1:0]  m_tag [3];
    logic [1:0]  sched [0:4095][0:2];
    int          cyc = 0;

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    task automatic model_reset();
        m_rot = 0;
        for (int p = 0; p < 3; p++) begin
            m_vld[p] = 1'b0; m_dat[p] = '0; m_tag[p] = 2'd0;
        end
        for (int c = cyc; c <= cyc + LAT; c++)
            for (int p = 0; p < 3; p++) sched[c][p] = 2'd0;
    endtask

    task automatic step(input logic [2:0] vv, input logic [W-1:0] x0, x1, x2, input logic st);
        int q[$];
        int r;
        v = vv; dd[0] = x0; dd[1] = x1; dd[2] = x2; stall = st;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else if (!st) begin
            for (int p = 0; p < 3; p++) begin
                m_vld[p] = 1'b0; m_dat[p] = '0; m_tag[p] = 2'd0;
            end
            for (int s = 0; s < 3; s++) begin
                r = (s + m_rot) % 3;
                if (vv[r]) begin
`ifdef PORT_PRIO_COMPACT_EN
                    q.push_back(r);
`else
                    m_vld[s] = 1'b1; m_dat[s] = dd[r]; m_tag[s] = 2'(r + 1);
`endif
                end
            end
            foreach (q[i]) begin
                m_vld[i] = 1'b1; m_dat[i] = dd[q[i]]; m_tag[i] = 2'(q[i] + 1);
            end
            for (int p = 0; p < 3; p++) sched[cyc + LAT][p] = m_tag[p];
            if (|vv) m_rot = (m_rot + 1) % 3;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        step(3'b000, '0, '0, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        stall = 1'b1; #1;
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_stalled: got %b want 0", req_ready); end
        stall = 1'b0; #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_free: got %b want 1", req_ready); end
        step(3'b111, 8'h11, 8'h22, 8'h33, 1'b0);
        n_checks++;
        if ({a_vld, a_dat, a_tag, a_rsp} !== '0)
            begin n_fail++; $display("FAIL reset_state: vld=%b dat=%h tag=%h rsp=%h want all 0", a_vld, a_dat, a_tag, a_rsp); end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step(3'($urandom), rnd(), rnd(), rnd(), 1'b0);
        rst_n = 1'b0; #1;
        n_checks++;
        if ({a_vld, a_dat, a_tag, a_rsp} !== '0)
            begin n_fail++; $display("FAIL reset_async: vld=%b dat=%h tag=%h rsp=%h want all 0", a_vld, a_dat, a_tag, a_rsp); end
        model_reset();
        step(3'b000, '0, '0, '0, 1'b0);
        rst_n = 1'b1;
        step(3'b111, 8'h11, 8'h22, 8'h33, 1'b0);
        n_checks++;
        if ({a_vld, a_tag, a_dat} !== {3'b111, 2'd3, 2'd2, 2'd1, 8'h33, 8'h22, 8'h11})
            begin n_fail++; $display("FAIL reset_first_issue: vld=%b tag=%h dat=%h want 111 tags 3,2,1 dat 332211", a_vld, a_tag, a_dat); end
        for (int k = 0; k < LAT; k++) begin
            step(3'b000, '0, '0, '0, 1'b0);
            n_checks++;
            if (a_rsp !== {sched[cyc][2], sched[cyc][1], sched[cyc][0]})
                begin n_fail++; $display("FAIL reset_rsp_flush k=%0d: got %h want %h", k, a_rsp, {sched[cyc][2], sched[cyc][1], sched[cyc][0]}); end
        end
    endtask

    task automatic test_full_load();
        int p2[3] = '{2, 3, 1};
        int p3[3] = '{3, 1, 2};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step(3'b111, W'(8'h10 | c), W'(8'h20 | c), W'(8'h30 | c), 1'b0);
            n_checks++;
            if (a_tag[0] !== 2'(c + 1) || a_tag[1] !== 2'(p2[c]) || a_tag[2] !== 2'(p3[c]))
                begin n_fail++; $display("FAIL full_load_tags c=%0d: got %h want %0d,%0d,%0d", c, a_tag, p3[c], p2[c], c + 1); end
            n_checks++;
            if (a_dat[0] !== W'(((c + 1) * 16) | c) || a_dat[2] !== W'((p3[c] * 16) | c) || a_vld !== 3'b111)
                begin n_fail++; $display("FAIL full_load_data c=%0d: got dat=%h vld=%b", c, a_dat, a_vld); end
        end
    endtask

    task automatic test_compaction();
        do_reset();
        step(3'b111, rnd(), rnd(), rnd(), 1'b0);
        step(3'b001, 8'hA5, 8'h00, 8'h00, 1'b0);
        n_checks++;
`ifdef PORT_PRIO_COMPACT_EN
        if ({a_vld, a_tag, a_dat} !== {3'b001, 2'd0, 2'd0, 2'd1, 8'h00, 8'h00, 8'hA5})
            begin n_fail++; $display("FAIL compact_lone: vld=%b tag=%h dat=%h want 001 tag 1 on port1 A5", a_vld, a_tag, a_dat); end
`else
        if ({a_vld, a_tag, a_dat} !== {3'b100, 2'd1, 2'd0, 2'd0, 8'hA5, 8'h00, 8'h00})
            begin n_fail++; $display("FAIL fixed_lone: vld=%b tag=%h dat=%h want 100 tag 1 on port3 A5", a_vld, a_tag, a_dat); end
`endif
    endtask

    task automatic test_stall();
        logic [2:0] s_vld; logic [2:0][W-1:0] s_dat; logic [2:0][1:0] s_tag;
        int cnt1, nz1;
        do_reset();
        step(3'b111, rnd(), rnd(), rnd(), 1'b0);
        s_vld = a_vld; s_dat = a_dat; s_tag = a_tag;
        cnt1 = 0; nz1 = 0;
        for (int k = 0; k < 2; k++) begin
            stall = 1'b1; #1;
            n_checks++;
            if (req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready k=%0d: got %b want 0", k, req_ready); end
            step(3'b111, rnd(), rnd(), rnd(), 1'b1);
            n_checks++;
            if ({a_vld, a_dat, a_tag} !== {s_vld, s_dat, s_tag})
                begin n_fail++; $display("FAIL stall_frozen k=%0d: got %b %h %h want %b %h %h", k, a_vld, a_dat, a_tag, s_vld, s_dat, s_tag); end
            if (a_rsp[0] == 2'd1) cnt1++;
            if (a_rsp[0] != 2'd0) nz1++;
        end
        step(3'b111, rnd(), rnd(), rnd(), 1'b0);
        n_checks++;
        if (a_tag !== {2'd1, 2'd3, 2'd2})
            begin n_fail++; $display("FAIL stall_fsm_held: got tags %h want 1,3,2", a_tag); end
        for (int k = 0; k < LAT + 3; k++) begin
            if (a_rsp[0] == 2'd1) cnt1++;
            if (a_rsp[0] != 2'd0) nz1++;
            step(3'b000, '0, '0, '0, 1'b0);
        end
        n_checks++;
        if (cnt1 !== 1) begin n_fail++; $display("FAIL stall_rsp_once: tag1 seen %0d times want 1", cnt1); end
        n_checks++;
        if (nz1 !== 2) begin n_fail++; $display("FAIL stall_rsp_total: nonzero %0d want 2", nz1); end
    endtask

    task automatic test_latency();
        do_reset();
        step(3'b001, rnd(), '0, '0, 1'b0);
        for (int k = 0; k < LAT + 1; k++) step(3'b000, '0, '0, '0, 1'b0);
        step(3'b010, '0, 8'h5C, '0, 1'b0);
        n_checks++;
        if (a_vld[0] !== 1'b1 || a_tag[0] !== 2'd2 || a_dat[0] !== 8'h5C)
            begin n_fail++; $display("FAIL lat_issue: vld=%b tag=%0d dat=%h want 1 2 5c", a_vld[0], a_tag[0], a_dat[0]); end
        for (int j = 0; j <= LAT + 2; j++) begin
            n_checks++;
            if (a_rsp[0] !== ((j == LAT) ? 2'd2 : 2'd0))
                begin n_fail++; $display("FAIL lat_rsp j=%0d: got %0d want %0d", j, a_rsp[0], (j == LAT) ? 2 : 0); end
            step(3'b000, '0, '0, '0, 1'b0);
        end
    endtask

    task automatic test_idle();
        do_reset();
        step(3'b111, rnd(), rnd(), rnd(), 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(3'b000, rnd(), rnd(), rnd(), 1'b0);
            n_checks++;
            if (a_vld !== 3'b000 || a_tag !== '0)
                begin n_fail++; $display("FAIL idle_empty k=%0d: vld=%b tag=%h want 0", k, a_vld, a_tag); end
        end
        step(3'b111, rnd(), rnd(), rnd(), 1'b0);
        n_checks++;
        if (a_tag !== {2'd1, 2'd3, 2'd2})
            begin n_fail++; $display("FAIL idle_resume: got tags %h want 1,3,2", a_tag); end
    endtask

    task automatic test_random();
        logic st;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            st = ($urandom_range(0, 3) == 0);
            stall = st; #1;
            n_checks++;
            if (req_ready !== ~st) begin n_fail++; $display("FAIL rand_ready k=%0d: got %b want %b", k, req_ready, ~st); end
            step(3'($urandom), rnd(), rnd(), rnd(), st);
            for (int p = 0; p < 3; p++) begin
                n_checks++;
                if ({a_vld[p], a_dat[p], a_tag[p], a_rsp[p]} !== {m_vld[p], m_dat[p], m_tag[p], sched[cyc][p]}) begin
                    n_fail++;
                    $display("FAIL rand_port%0d k=%0d: got vld=%b dat=%h tag=%0d rsp=%0d want vld=%b dat=%h tag=%0d rsp=%0d",
                             p + 1, k, a_vld[p], a_dat[p], a_tag[p], a_rsp[p], m_vld[p], m_dat[p], m_tag[p], sched[cyc][p]);
                end
            end
        end
    endtask

    initial begin
        for (int c = 0; c < 4096; c++)
            for (int p = 0; p < 3; p++) sched[c][p] = 2'd0;
        model_reset();
        test_reset();
        test_full_load();
        test_compaction();
        test_stall();
        test_latency();
        test_idle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
